// File: rtl/symbiface_ps2_mouse_rx_pkg.sv
// Shared types and bus layout for the PS/2 mouse receiver.
package symbiface_ps2_mouse_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam int unsigned MS_STATUS_LSB   = 0;
  localparam int unsigned MS_STATUS_MSB   = 7;
  localparam int unsigned MS_DX_LSB       = 8;
  localparam int unsigned MS_DX_MSB       = 15;
  localparam int unsigned MS_DY_LSB       = 16;
  localparam int unsigned MS_DY_MSB       = 23;
  localparam int unsigned MS_TOGGLE       = 24;
  localparam int unsigned STATUS_SYNC_BIT = 3;

  localparam int unsigned DEF_FILTER_LEN = 8;
  localparam int unsigned DEF_TIMEOUT    = 100000;

endpackage

// File: rtl/symbiface_ps2_mouse_rx_line_filter.sv
// Two-FF synchroniser followed by a run-length glitch filter; idles high.
module ps2_line_filter
  import symbiface_ps2_mouse_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the number of differing samples seen so far; the
  // FILTER_LEN-th consecutive one flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/symbiface_ps2_mouse_rx.sv
// PS/2 mouse receiver: deframes 11-bit frames and assembles 3-byte packets.
module symbiface_ps2_mouse_rx
  import symbiface_ps2_mouse_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [24:0] ps2_mouse,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  logic clk_f, data_f, clk_prev_q, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i(clk_sys), .rst_ni(reset_n), .pin_i(ps2_clk), .level_o(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_i(clk_sys), .rst_ni(reset_n), .pin_i(ps2_data), .level_o(data_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  frame_state_e  state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    dx_q, dx_d;
  logic [24:0]   mouse_q, mouse_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    status_d = status_q;
    dx_d     = dx_q;
    mouse_d  = mouse_q;
    err_d    = 1'b0;
    tmo_d    = '0;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shreg_d  = {data_f, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_f;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_f && (^shreg_q ^ parity_q)) begin
            unique case (idx_q)
              2'd0: begin
                if (shreg_q[STATUS_SYNC_BIT]) begin
                  status_d = shreg_q;
                  idx_d    = 2'd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              2'd1: begin
                dx_d  = shreg_q;
                idx_d = 2'd2;
              end
              default: begin
                mouse_d[MS_STATUS_MSB:MS_STATUS_LSB] = status_q;
                mouse_d[MS_DX_MSB:MS_DX_LSB]         = dx_q;
                mouse_d[MS_DY_MSB:MS_DY_LSB]         = shreg_q;
                mouse_d[MS_TOGGLE]                   = ~mouse_q[MS_TOGGLE];
                idx_d                                = 2'd0;
              end
            endcase
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE || idx_q != 2'd0) begin
      // A strobe always takes priority over the limit, hence the else-branch.
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      idx_q      <= '0;
      status_q   <= '0;
      dx_q       <= '0;
      mouse_q    <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      idx_q      <= idx_d;
      status_q   <= status_d;
      dx_q       <= dx_d;
      mouse_q    <= mouse_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_symbiface_ps2_mouse_rx.sv
// Self-checking bench for the PS/2 mouse receiver.
module tb_symbiface_ps2_mouse_rx;

  localparam int HALF = 20;
  localparam int FL   = 8;
  localparam int TMO  = 1000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;

  symbiface_ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk),
    .ps2_data(ps2_data), .ps2_mouse(ps2_mouse), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  always @(negedge clk_sys) if (frame_err === 1'b1) err_seen++;

  // Behavioural reference: packet rules applied to whole received bytes.
  logic [24:0] m_mouse;
  int          m_idx;
  logic [7:0]  m_stat, m_dx;
  int          m_err;

  task automatic model_reset();
    m_mouse = '0; m_idx = 0; m_stat = '0; m_dx = '0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++; m_idx = 0;
    end else if (m_idx == 0) begin
      if (b[3]) begin m_stat = b; m_idx = 1; end
      else m_err++;
    end else if (m_idx == 1) begin
      m_dx = b; m_idx = 2;
    end else begin
      m_mouse = {~m_mouse[24], b, m_dx, m_stat}; m_idx = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives nbits of an 11-bit frame; optionally checks update latency on the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit lat, input logic [24:0] exp_old,
                            input logic [24:0] exp_new, input logic exp_pulse);
    logic [10:0] f;
    f[0] = 1'b0;
    f[8:1] = b;
    f[9] = ~(^b) ^ bad_par;
    f[10] = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk_sys); #1 ps2_data = f[i];
      repeat (HALF) @(posedge clk_sys);
      #1 ps2_clk = 1'b0;
      if (lat && i == 10) begin
        repeat (10) @(posedge clk_sys);
        #1 chk("lat_mouse_before", ps2_mouse, exp_old);
        chk("lat_err_before", frame_err, 0);
        @(posedge clk_sys);
        #1 chk("lat_mouse_after", ps2_mouse, exp_new);
        chk("lat_err_after", frame_err, exp_pulse);
        repeat (HALF - 11) @(posedge clk_sys);
      end else begin
        repeat (HALF) @(posedge clk_sys);
      end
      #1 ps2_clk = 1'b1;
    end
    @(posedge clk_sys); #1 ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk_sys);
    if (nbits == 11) model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, 1'b0, '0, '0, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          lat;
    logic [24:0] exp_mouse;
    int          exp_errs;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int prev_errs;
    logic [24:0] prev_mouse;
    logic [7:0] rb;
    bit bp, bs;

    tbl[0]  = '{8'h29, 1'b0, 1'b0, 25'h0000000, 0};
    tbl[1]  = '{8'h05, 1'b0, 1'b0, 25'h0000000, 0};
    tbl[2]  = '{8'hFB, 1'b0, 1'b1, 25'h1FB0529, 0};
    tbl[3]  = '{8'h29, 1'b0, 1'b0, 25'h1FB0529, 0};
    tbl[4]  = '{8'h05, 1'b0, 1'b0, 25'h1FB0529, 0};
    tbl[5]  = '{8'hFB, 1'b0, 1'b1, 25'h0FB0529, 0};
    tbl[6]  = '{8'h05, 1'b1, 1'b1, 25'h0FB0529, 1};
    tbl[7]  = '{8'h08, 1'b0, 1'b0, 25'h0FB0529, 1};
    tbl[8]  = '{8'h01, 1'b0, 1'b0, 25'h0FB0529, 1};
    tbl[9]  = '{8'h02, 1'b0, 1'b1, 25'h1020108, 1};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 25'h1020108, 2};
    tbl[11] = '{8'h09, 1'b0, 1'b0, 25'h1020108, 2};
    tbl[12] = '{8'h10, 1'b0, 1'b0, 25'h1020108, 2};
    tbl[13] = '{8'h20, 1'b0, 1'b1, 25'h0201009, 2};

    model_reset();
    m_err = 0;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(posedge clk_sys);
    #1 chk("reset_mouse", ps2_mouse, 0);
    chk("reset_err", frame_err, 0);
    repeat (2 * HALF) @(posedge clk_sys);

    prev_errs = 0;
    prev_mouse = '0;
    for (int i = 0; i < 14; i++) begin
      send_frame(tbl[i].b, tbl[i].bad_par, 1'b0, 11, tbl[i].lat, prev_mouse,
                 tbl[i].exp_mouse, 1'(tbl[i].exp_errs != prev_errs));
      chk($sformatf("tbl%0d_mouse", i), ps2_mouse, tbl[i].exp_mouse);
      chk($sformatf("tbl%0d_errs", i), err_seen, tbl[i].exp_errs);
      prev_errs = tbl[i].exp_errs;
      prev_mouse = tbl[i].exp_mouse;
    end

    // Partial packet abandoned by the idle timeout.
    send_good(8'h18);
    send_good(8'h7F);
    repeat (TMO + 100) @(posedge clk_sys);
    m_idx = 0;
    send_good(8'h0A);
    send_good(8'h03);
    send_good(8'h04);
    chk("timeout_mouse", ps2_mouse, 25'h104030A);
    chk("timeout_errs", err_seen, 2);

    // Clock glitch one sample short of the filter length, with data low.
    @(posedge clk_sys); #1 ps2_data = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1 ps2_clk = 1'b0;
    repeat (FL - 1) @(posedge clk_sys);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk_sys);
    send_good(8'h0C);
    send_good(8'h11);
    send_good(8'h22);
    chk("glitch_mouse", ps2_mouse, 25'h022110C);
    chk("glitch_errs", err_seen, 2);

    // Reset in the middle of the third byte.
    send_good(8'h28);
    send_good(8'h44);
    send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0, '0, '0, 1'b0);
    @(posedge clk_sys); #1 reset_n = 1'b0;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    chk("midreset_mouse", ps2_mouse, 0);
    chk("midreset_err", frame_err, 0);
    model_reset();
    repeat (2 * HALF) @(posedge clk_sys);
    send_good(8'h28);
    send_good(8'h44);
    send_good(8'h55);
    chk("postreset_mouse", ps2_mouse, 25'h1554428);
    chk("postreset_errs", err_seen, 2);

    // Randomised frames against the reference model.
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      if (m_idx == 0 && $urandom_range(0, 3) != 0) rb[3] = 1'b1;
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      send_frame(rb, bp, bs, 11, 1'b0, '0, '0, 1'b0);
      chk($sformatf("rand%0d_mouse", i), ps2_mouse, m_mouse);
      chk($sformatf("rand%0d_errs", i), err_seen, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
